// File: rtl/lenet_pkg.sv
// Shared constants and FSM state encoding for the LeNet accelerator layer scheduler.
package lenet_pkg;

    localparam int unsigned NUM_LAYERS  = 6;
    localparam int unsigned DATA_SIZE   = 8;
    localparam int unsigned BW_ADDR_W   = 19;
    localparam int unsigned RES_ADDR_W  = 15;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned GUARD_CYC   = 2;

    localparam logic [2:0] L_CONV1 = 3'd0;
    localparam logic [2:0] L_POOL1 = 3'd1;
    localparam logic [2:0] L_CONV2 = 3'd2;
    localparam logic [2:0] L_POOL2 = 3'd3;
    localparam logic [2:0] L_FC1   = 3'd4;
    localparam logic [2:0] L_FC2   = 3'd5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_LAUNCH = 6'b000010,
        S_RUN    = 6'b000100,
        S_NEXT   = 6'b001000,
        S_ARGMAX = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

endpackage

// File: rtl/lenet_bram_arbiter.sv
// Combinational routing of the selected layer's BRAM requests onto the shared ports.
module lenet_bram_arbiter #(
    parameter int unsigned NUM_LAYERS = lenet_pkg::NUM_LAYERS,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DATA_SIZE  = lenet_pkg::DATA_SIZE,
    parameter int unsigned BW_ADDR_W  = lenet_pkg::BW_ADDR_W,
    parameter int unsigned RES_ADDR_W = lenet_pkg::RES_ADDR_W
) (
    input  logic [SEL_W-1:0]                 sel,
    input  logic                             idle,
    input  logic [NUM_LAYERS-1:0]            bw_ena_i,
    input  logic [NUM_LAYERS*BW_ADDR_W-1:0]  bw_addr_i,
    input  logic [NUM_LAYERS-1:0]            res_ena_i,
    input  logic [NUM_LAYERS-1:0]            res_wea_i,
    input  logic [NUM_LAYERS*RES_ADDR_W-1:0] res_addr_i,
    input  logic [NUM_LAYERS*DATA_SIZE-1:0]  res_din_i,
    output logic                             bw_ena,
    output logic [BW_ADDR_W-1:0]             bw_addr,
    output logic                             res_ena,
    output logic                             res_wea,
    output logic [RES_ADDR_W-1:0]            res_addr,
    output logic [DATA_SIZE-1:0]             res_din
);

    always_comb begin
        bw_ena   = 1'b0;
        bw_addr  = '0;
        res_ena  = 1'b0;
        res_wea  = 1'b0;
        res_addr = '0;
        res_din  = '0;
        if (!idle) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (sel == SEL_W'(i)) begin
                    bw_ena   = bw_ena_i[i];
                    bw_addr  = bw_addr_i[i*BW_ADDR_W +: BW_ADDR_W];
                    res_ena  = res_ena_i[i];
                    res_wea  = res_wea_i[i];
                    res_addr = res_addr_i[i*RES_ADDR_W +: RES_ADDR_W];
                    res_din  = res_din_i[i*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

endmodule

// File: rtl/lenet_layer_scheduler.sv
// Sequences the six LeNet layers, shares the BRAM ports and picks the argmax class.
// Optional per-layer cycle counters when LAYER_PERF_EN is defined.
module lenet_layer_scheduler #(
    parameter int unsigned NUM_LAYERS  = lenet_pkg::NUM_LAYERS,
    parameter int unsigned DATA_SIZE   = lenet_pkg::DATA_SIZE,
    parameter int unsigned BW_ADDR_W   = lenet_pkg::BW_ADDR_W,
    parameter int unsigned RES_ADDR_W  = lenet_pkg::RES_ADDR_W,
    parameter int unsigned NUM_CLASSES = lenet_pkg::NUM_CLASSES,
    parameter int unsigned GUARD_CYC   = lenet_pkg::GUARD_CYC
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_LAYERS-1:0]             layer_en,
    input  logic [NUM_LAYERS-1:0]             layer_finish,
    input  logic [NUM_LAYERS-1:0]             bw_ena_i,
    input  logic [NUM_LAYERS*BW_ADDR_W-1:0]   bw_addr_i,
    input  logic [NUM_LAYERS-1:0]             res_ena_i,
    input  logic [NUM_LAYERS-1:0]             res_wea_i,
    input  logic [NUM_LAYERS*RES_ADDR_W-1:0]  res_addr_i,
    input  logic [NUM_LAYERS*DATA_SIZE-1:0]   res_din_i,
    output logic                              bw_ena,
    output logic [BW_ADDR_W-1:0]              bw_addr,
    output logic                              res_ena,
    output logic                              res_wea,
    output logic [RES_ADDR_W-1:0]             res_addr,
    output logic [DATA_SIZE-1:0]              res_din,
    input  logic [NUM_CLASSES*DATA_SIZE-1:0]  fc2_scores,
    output logic [NUM_CLASSES*DATA_SIZE-1:0]  scores,
    output logic [3:0]                        class_id,
    output logic                              class_valid
`ifdef LAYER_PERF_EN
    ,
    input  logic [2:0]                        perf_sel,
    output logic [31:0]                       perf_cnt
`endif
);

    import lenet_pkg::*;

    localparam int unsigned LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned GW = $clog2(GUARD_CYC + 2);
    localparam int unsigned CW = 4;

    state_t                       state, state_nxt;
    logic [LW-1:0]                cur_layer;
    logic [GW-1:0]                guard;
    logic [CW-1:0]                arg_k;
    logic [CW-1:0]                best_idx;
    logic signed [DATA_SIZE-1:0]  best_val;
    logic signed [DATA_SIZE-1:0]  score_arr [NUM_CLASSES];
    logic                         active, last_layer, arg_last, finish_seen, take;
    logic [CW-1:0]                new_idx;

    assign active      = (state == S_LAUNCH) || (state == S_RUN);
    assign last_layer  = (cur_layer == LW'(NUM_LAYERS - 1));
    assign arg_last    = (arg_k == CW'(NUM_CLASSES - 1));
    assign finish_seen = (guard == '0) && layer_finish[cur_layer];

    // Class 0 occupies the most significant byte of the score vector.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++)
            score_arr[k] = scores[DATA_SIZE*(NUM_CLASSES-k)-1 -: DATA_SIZE];
    end

    assign take    = (arg_k == '0) || (score_arr[arg_k] > best_val);
    assign new_idx = take ? arg_k : best_idx;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        layer_en  = '0;
        case (state)
            S_IDLE:   begin busy = 1'b0; if (start) state_nxt = S_LAUNCH; end
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (finish_seen) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = last_layer ? S_ARGMAX : S_LAUNCH;
            S_ARGMAX: if (arg_last) state_nxt = S_DONE;
            S_DONE:   begin busy = 1'b0; done = 1'b1; state_nxt = S_IDLE; end
            default:  begin busy = 1'b0; state_nxt = S_IDLE; end
        endcase
        if (active) layer_en = NUM_LAYERS'(1) << cur_layer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_layer   <= '0;
            guard       <= '0;
            arg_k       <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            scores      <= '0;
            class_id    <= '0;
            class_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cur_layer   <= '0;
                    class_valid <= 1'b0;
                end
                S_LAUNCH: guard <= GW'(GUARD_CYC);
                S_RUN:    if (guard != '0) guard <= guard - 1'b1;
                S_NEXT: begin
                    if (last_layer) begin
                        scores <= fc2_scores;
                        arg_k  <= '0;
                    end else begin
                        cur_layer <= cur_layer + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    if (take) begin
                        best_val <= score_arr[arg_k];
                        best_idx <= arg_k;
                    end
                    arg_k <= arg_k + 1'b1;
                    if (arg_last) begin
                        class_id    <= new_idx;
                        class_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    lenet_bram_arbiter #(
        .NUM_LAYERS (NUM_LAYERS),
        .SEL_W      (LW),
        .DATA_SIZE  (DATA_SIZE),
        .BW_ADDR_W  (BW_ADDR_W),
        .RES_ADDR_W (RES_ADDR_W)
    ) u_arbiter (
        .sel        (cur_layer),
        .idle       (!active),
        .bw_ena_i   (bw_ena_i),
        .bw_addr_i  (bw_addr_i),
        .res_ena_i  (res_ena_i),
        .res_wea_i  (res_wea_i),
        .res_addr_i (res_addr_i),
        .res_din_i  (res_din_i),
        .bw_ena     (bw_ena),
        .bw_addr    (bw_addr),
        .res_ena    (res_ena),
        .res_wea    (res_wea),
        .res_addr   (res_addr),
        .res_din    (res_din)
    );

`ifdef LAYER_PERF_EN
    logic [31:0] perf_reg [NUM_LAYERS];

    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) perf_reg[i] <= '0;
        end else if (active && perf_reg[cur_layer] != '1) begin
            perf_reg[cur_layer] <= perf_reg[cur_layer] + 1'b1;
        end
    end

    always_comb begin
        perf_cnt = '0;
        if (32'(perf_sel) < NUM_LAYERS) perf_cnt = perf_reg[perf_sel];
    end
`endif

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Self-checking bench for lenet_layer_scheduler with stub layers and a launch/class scoreboard.
module tb_lenet_layer_scheduler;

    localparam int NL    = 6;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done;
    logic [5:0]  layer_en, layer_finish;
    logic [5:0]  bw_ena_i, res_ena_i, res_wea_i;
    logic [NL*19-1:0] bw_addr_i;
    logic [NL*15-1:0] res_addr_i;
    logic [NL*8-1:0]  res_din_i;
    logic        bw_ena, res_ena, res_wea;
    logic [18:0] bw_addr;
    logic [14:0] res_addr;
    logic [7:0]  res_din;
    logic [79:0] fc2_scores, scores;
    logic [3:0]  class_id;
    logic        class_valid;
`ifdef LAYER_PERF_EN
    logic [2:0]  perf_sel;
    logic [31:0] perf_cnt;
`endif

    lenet_layer_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .layer_en(layer_en), .layer_finish(layer_finish),
        .bw_ena_i(bw_ena_i), .bw_addr_i(bw_addr_i),
        .res_ena_i(res_ena_i), .res_wea_i(res_wea_i),
        .res_addr_i(res_addr_i), .res_din_i(res_din_i),
        .bw_ena(bw_ena), .bw_addr(bw_addr), .res_ena(res_ena), .res_wea(res_wea),
        .res_addr(res_addr), .res_din(res_din),
        .fc2_scores(fc2_scores), .scores(scores),
        .class_id(class_id), .class_valid(class_valid)
`ifdef LAYER_PERF_EN
        , .perf_sel(perf_sel), .perf_cnt(perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         lat   [NL];
    int         cnt   [NL];
    logic [5:0] stale;
    logic [18:0] bw_tab  [NL] = '{19'h00111, 19'h00222, 19'h12345, 19'h7FFFF, 19'h00444, 19'h00555};
    logic [14:0] ra_tab  [NL] = '{15'h0101, 15'h0202, 15'h0303, 15'h0404, 15'h0505, 15'h0606};
    logic [7:0]  rd_tab  [NL] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    int         en_q  [$];
    logic [3:0] cls_q [$];

    // Stub layers: finish rises after lat[i] enabled cycles; a stale flag stays high through the guard window.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (layer_en[i] === 1'b1) cnt[i]++;
            else cnt[i] = 0;
            layer_finish[i] = (stale[i] && cnt[i] <= GUARD + 1) || (cnt[i] >= lat[i]);
        end
    end

    function automatic logic [79:0] pack_scores(input logic [7:0] v [10]);
        logic [79:0] r;
        for (int k = 0; k < 10; k++) r[8*(10-k)-1 -: 8] = v[k];
        return r;
    endfunction

    task automatic run_inference(input logic [79:0] sc, input logic [3:0] exp_cls, input bit poke);
        bit fin;
        int post, dur, gap, act, dones;
        bit first;
        logic [5:0]  prev_en, cur;
        logic [44:0] exp_arb, got_arb;
        fin = 0; post = 0; dur = 0; gap = 0; act = 0; dones = 0; first = 1; prev_en = '0;
        for (int i = 0; i < NL; i++) en_q.push_back(i);
        cls_q.push_back(exp_cls);
        fc2_scores = sc;
        start = 1'b1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0;
                checks++;
                if (class_valid !== 1'b0) begin
                    errors++; $display("FAIL valid_clear got %b want 0", class_valid);
                end
            end
            if (poke && c == 30) start = 1'b1;
            if (poke && c == 31) start = 1'b0;
            cur = layer_en;
            if (cur !== prev_en) begin
                if (prev_en != 0) begin
                    checks++;
                    if (dur !== lat[act]) begin
                        errors++; $display("FAIL layer_len layer %0d got %0d want %0d", act, dur, lat[act]);
                    end
                end
                if (cur != 0) begin
                    if (en_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_launch got %h want none", cur);
                    end else begin
                        act = en_q.pop_front();
                        checks++;
                        if (cur !== (6'b1 << act)) begin
                            errors++; $display("FAIL launch_order got %h want %h", cur, 6'b1 << act);
                        end
                        checks++;
                        if (first ? (c != 0) : (gap != 1)) begin
                            errors++; $display("FAIL launch_gap got c=%0d gap=%0d want c=0 or gap=1", c, gap);
                        end
                    end
                    first = 0;
                    dur = 0;
                end
                gap = 0;
            end
            if (cur != 0) dur++;
            else gap++;
            prev_en = cur;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (gap !== 12) begin
                    errors++; $display("FAIL argmax_len got %0d want 12", gap);
                end
                if (cls_q.size() != 0) begin
                    logic [3:0] ec;
                    ec = cls_q.pop_front();
                    checks++;
                    if (class_id !== ec) begin
                        errors++; $display("FAIL class_id got %0d want %0d", class_id, ec);
                    end
                end
                checks++;
                if (class_valid !== 1'b1) begin
                    errors++; $display("FAIL class_valid got %b want 1", class_valid);
                end
                checks++;
                if (scores !== sc) begin
                    errors++; $display("FAIL scores got %h want %h", scores, sc);
                end
            end
            exp_arb = (cur != 0) ? {1'b1, bw_tab[act], 1'b1, res_wea_i[act], ra_tab[act], rd_tab[act]} : '0;
            got_arb = {bw_ena, bw_addr, res_ena, res_wea, res_addr, res_din};
            checks++;
            if (got_arb !== exp_arb) begin
                errors++; $display("FAIL arbiter c=%0d got %h want %h", c, got_arb, exp_arb);
            end
            checks++;
            if (busy !== (dones == 0)) begin
                errors++; $display("FAIL busy c=%0d got %b want %b", c, busy, dones == 0);
            end
            if (dones > 0) begin
                post++;
                if (post > 3) fin = 1;
            end
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL timeout got no done want done");
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL done_pulses got %0d want 1", dones);
        end
        checks++;
        if (en_q.size() != 0 || cls_q.size() != 0) begin
            errors++; $display("FAIL missing_launch got %0d left want 0", en_q.size());
        end
        en_q.delete();
        cls_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, layer_en, class_valid, class_id} !== '0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {busy, done, layer_en, class_valid, class_id});
        end
        checks++;
        if ({bw_ena, bw_addr, res_ena, res_wea, res_addr, res_din} !== '0) begin
            errors++; $display("FAIL reset_bram got %h want 0", {bw_ena, bw_addr, res_ena, res_wea, res_addr, res_din});
        end
        checks++;
        if (scores !== '0) begin
            errors++; $display("FAIL reset_scores got %h want 0", scores);
        end
    endtask

    task automatic test_sequence;
        logic [7:0] v [10];
        v = '{8'd5, 8'hFD, 8'd127, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_inference(pack_scores(v), 4'd2, 1'b1);
    endtask

    task automatic test_argmax;
        logic [7:0] v [10];
        v = '{default: 8'h80};
        run_inference(pack_scores(v), 4'd0, 1'b0);
        v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd99, 8'hFF, 8'h80, 8'hFF, 8'hFF, 8'd100};
        run_inference(pack_scores(v), 4'd9, 1'b0);
    endtask

    task automatic test_stale;
        logic [7:0] v [10];
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0};
        stale = 6'b001001;
        @(negedge clk);
        run_inference(pack_scores(v), 4'd8, 1'b0);
        stale = '0;
    endtask

    task automatic test_reset_midrun;
        logic [7:0] v [10];
        bit found;
        found = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (layer_en === 6'h10) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reach_layer4 got %h want 10", layer_en);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({layer_en, res_ena, bw_ena, busy} !== '0) begin
            errors++; $display("FAIL midrun_reset got %b want 0", {layer_en, res_ena, bw_ena, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        v = '{8'h90, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        run_inference(pack_scores(v), 4'd1, 1'b0);
    endtask

`ifdef LAYER_PERF_EN
    task automatic test_perf;
        logic [7:0] v [10];
        v = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        lat[1] = 50;
        run_inference(pack_scores(v), 4'd0, 1'b0);
        perf_sel = 3'd1;
        #1;
        checks++;
        if (perf_cnt !== 32'd50) begin
            errors++; $display("FAIL perf_l1 got %0d want 50", perf_cnt);
        end
        perf_sel = 3'd0;
        #1;
        checks++;
        if (perf_cnt !== 32'd20) begin
            errors++; $display("FAIL perf_l0 got %0d want 20", perf_cnt);
        end
        perf_sel = 3'd6;
        #1;
        checks++;
        if (perf_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_sel6 got %0d want 0", perf_cnt);
        end
        perf_sel = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (perf_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_clear got %0d want 0", perf_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat[1] = 20;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stale = '0;
        fc2_scores = '0;
        for (int i = 0; i < NL; i++) begin
            lat[i] = 20;
            cnt[i] = 0;
            bw_addr_i[i*19 +: 19] = bw_tab[i];
            res_addr_i[i*15 +: 15] = ra_tab[i];
            res_din_i[i*8 +: 8] = rd_tab[i];
        end
        bw_ena_i  = 6'b111111;
        res_ena_i = 6'b111111;
        res_wea_i = 6'b010101;
`ifdef LAYER_PERF_EN
        perf_sel = 3'd0;
`endif
        test_reset();
        test_sequence();
        test_argmax();
        test_stale();
        test_reset_midrun();
`ifdef LAYER_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
